// File: rtl/maze_pkg.sv
// Shared types and constants for the maze memory arbiter.
package maze_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  typedef enum logic {
    REQ_RAT,
    REQ_HOST
  } req_id_t;

  localparam int STAT_W = 16;

  // Memory address width for an N-bit coordinate pair {y, x}.
  function automatic int addr_w(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/maze_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the maze RAM.
// slave: arbiter view. master: requester/memory environment view.
interface maze_mem_arbiter_if #(parameter int N = 4);
  import maze_pkg::*;

  localparam int AW = addr_w(N);

  logic          rat_rd;
  logic          rat_wr;
  logic [N-1:0]  rat_x;
  logic [N-1:0]  rat_y;
  logic          rat_wdata;
  logic          rat_rdata;
  logic          rat_ack;

  logic          host_rd;
  logic          host_wr;
  logic [AW-1:0] host_addr;
  logic          host_wdata;
  logic          host_lock;
  logic          host_rdata;
  logic          host_ack;

  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic          mem_din;
  logic          mem_dout;

  logic          busy;

  modport slave (
    input  rat_rd, rat_wr, rat_x, rat_y, rat_wdata,
    output rat_rdata, rat_ack,
    input  host_rd, host_wr, host_addr, host_wdata, host_lock,
    output host_rdata, host_ack,
    output mem_addr, mem_rd, mem_wr, mem_din,
    input  mem_dout,
    output busy
  );

  modport master (
    output rat_rd, rat_wr, rat_x, rat_y, rat_wdata,
    input  rat_rdata, rat_ack,
    output host_rd, host_wr, host_addr, host_wdata, host_lock,
    input  host_rdata, host_ack,
    input  mem_addr, mem_rd, mem_wr, mem_din,
    output mem_dout,
    input  busy
  );

endinterface

// File: rtl/maze_mem_arbiter_rr_arb2.sv
// Combinational 2-way round-robin picker; mask_rat hides the rat while the host holds the lock.
module rr_arb2
  import maze_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_t    last,
  input  logic       mask_rat,
  output logic       gnt_valid,
  output req_id_t    gnt_id
);

  logic [1:0] eff;

  // Pick the active requester; on contention prefer the one not granted last.
  always_comb begin
    eff       = {req[1], req[0] & ~mask_rat};
    gnt_valid = |eff;
    gnt_id    = REQ_RAT;
    if (eff == 2'b11) begin
      gnt_id = (last == REQ_RAT) ? REQ_HOST : REQ_RAT;
    end else if (eff[1]) begin
      gnt_id = REQ_HOST;
    end
  end

endmodule

// File: rtl/maze_mem_arbiter.sv
// Maze RAM arbiter: rat solver vs host port, IDLE -> ACCESS -> RESP sequencer.
// Optional ack/conflict statistics are built when MAZE_ARB_STATS_EN is defined.
//
//   state  | meaning
//   IDLE   | pick a winner, capture its op/address/data
//   ACCESS | drive memory strobe for the captured op
//   RESP   | one-cycle ack to winner, read data from mem_dout
module maze_mem_arbiter
  import maze_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                clk,
  input  logic                rst,
  maze_mem_arbiter_if.slave   bus
`ifdef MAZE_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0]   rat_cnt,
  output logic [STAT_W-1:0]   host_cnt,
  output logic [STAT_W-1:0]   conflict_cnt
`endif
);

  localparam int AW = addr_w(N);

  arb_state_t    state_q, state_d;
  req_id_t       last_q, last_d;
  req_id_t       id_q, id_d;
  logic          locked_q, locked_d;
  logic          wr_q, wr_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          wdata_q, wdata_d;

  logic    rat_act, host_act;
  logic    gnt_valid;
  req_id_t gnt_id;
  logic    rat_ack_w, host_ack_w;

  assign rat_act  = bus.rat_rd | bus.rat_wr;
  assign host_act = bus.host_rd | bus.host_wr;

  rr_arb2 u_rr_arb2 (
    .req       ({host_act, rat_act}),
    .last      (last_q),
    .mask_rat  (locked_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // State and captured-transaction registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      last_q   <= REQ_HOST;
      id_q     <= REQ_RAT;
      locked_q <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      id_q     <= id_d;
      locked_q <= locked_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
    end
  end

  // Next-state: arbitrate and capture in IDLE, sample host_lock in a host RESP.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    id_d     = id_q;
    locked_d = locked_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    case (state_q)
      IDLE: begin
        if (locked_q && !bus.host_lock) locked_d = 1'b0;
        if (gnt_valid) begin
          id_d    = gnt_id;
          last_d  = gnt_id;
          state_d = ACCESS;
          if (gnt_id == REQ_HOST) begin
            wr_d    = bus.host_wr;
            addr_d  = bus.host_addr;
            wdata_d = bus.host_wdata;
          end else begin
            wr_d    = bus.rat_wr;
            addr_d  = {bus.rat_y, bus.rat_x};
            wdata_d = bus.rat_wdata;
          end
        end
      end
      ACCESS: state_d = RESP;
      RESP: begin
        state_d = IDLE;
        if (id_q == REQ_HOST) locked_d = bus.host_lock;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rat_ack_w  = (state_q == RESP) && (id_q == REQ_RAT);
  assign host_ack_w = (state_q == RESP) && (id_q == REQ_HOST);

  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd     = (state_q == ACCESS) && !wr_q;
  assign bus.mem_wr     = (state_q == ACCESS) && wr_q;
  assign bus.mem_din    = (state_q == ACCESS) && wdata_q;
  assign bus.rat_ack    = rat_ack_w;
  assign bus.host_ack   = host_ack_w;
  assign bus.rat_rdata  = rat_ack_w && !wr_q && bus.mem_dout;
  assign bus.host_rdata = host_ack_w && !wr_q && bus.mem_dout;
  assign bus.busy       = (state_q != IDLE);

`ifdef MAZE_ARB_STATS_EN
  logic [STAT_W-1:0] rat_cnt_q, host_cnt_q, conf_cnt_q;
  logic              conflict;

  assign conflict = (state_q == IDLE) && rat_act && (host_act || locked_q);

  // Saturating ack and contention counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      rat_cnt_q  <= '0;
      host_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else begin
      if (rat_ack_w && (rat_cnt_q != '1))   rat_cnt_q  <= rat_cnt_q + STAT_W'(1);
      if (host_ack_w && (host_cnt_q != '1)) host_cnt_q <= host_cnt_q + STAT_W'(1);
      if (conflict && (conf_cnt_q != '1))   conf_cnt_q <= conf_cnt_q + STAT_W'(1);
    end
  end

  assign rat_cnt      = rat_cnt_q;
  assign host_cnt     = host_cnt_q;
  assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_maze_mem_arbiter.sv
// Scoreboard bench for maze_mem_arbiter: drivers push expected acks, a negedge monitor pops and checks.
module tb_maze_mem_arbiter;
  import maze_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  maze_mem_arbiter_if #(.N(4)) bus ();

`ifdef MAZE_ARB_STATS_EN
  logic [STAT_W-1:0] rat_cnt, host_cnt, conflict_cnt;
`endif

  maze_mem_arbiter #(.N(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MAZE_ARB_STATS_EN
    ,
    .rat_cnt      (rat_cnt),
    .host_cnt     (host_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  // Maze RAM model with registered read data.
  logic       tmem [256];
  logic       mem_dout_r = 1'b0;
  logic       mem_clr, pl_we;
  logic [7:0] pl_addr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) tmem[i] <= 1'b0;
    end else if (pl_we) begin
      tmem[pl_addr] <= 1'b1;
    end else if (bus.mem_wr) begin
      tmem[bus.mem_addr] <= bus.mem_din;
    end
    if (bus.mem_rd) mem_dout_r <= tmem[bus.mem_addr];
  end
  assign bus.mem_dout = mem_dout_r;

  typedef struct {
    logic is_host;
    logic rdata;
  } exp_t;
  exp_t sb_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every ack must match the next scoreboard entry; rdata idles at 0.
  exp_t e;
  always @(negedge clk) begin
    chk("strobe_excl", {31'd0, bus.mem_rd & bus.mem_wr}, 0);
    if (!bus.rat_ack)  chk("rat_rdata_idle", {31'd0, bus.rat_rdata}, 0);
    if (!bus.host_ack) chk("host_rdata_idle", {31'd0, bus.host_rdata}, 0);
    if (bus.rat_ack || bus.host_ack) begin
      chk("single_ack", {31'd0, bus.rat_ack & bus.host_ack}, 0);
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack actual rat=%0b host=%0b required none", bus.rat_ack, bus.host_ack);
      end else begin
        e = sb_q.pop_front();
        chk("ack_id", {31'd0, bus.host_ack}, {31'd0, e.is_host});
        chk("ack_rdata", {31'd0, bus.host_ack ? bus.host_rdata : bus.rat_rdata}, {31'd0, e.rdata});
      end
    end
  end

  task automatic push(input logic is_host, input logic rd);
    exp_t x;
    x.is_host = is_host;
    x.rdata   = rd;
    sb_q.push_back(x);
  endtask

  task automatic rat_txn(input logic wr, input logic [3:0] x, input logic [3:0] y, input logic d);
    logic got = 1'b0;
    bus.rat_wr = wr; bus.rat_rd = ~wr; bus.rat_x = x; bus.rat_y = y; bus.rat_wdata = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.rat_ack) got = 1'b1;
    end
    chk("rat_ack_timeout", {31'd0, got}, 1);
    bus.rat_wr = 1'b0; bus.rat_rd = 1'b0;
  endtask

  task automatic host_txn(input logic wr, input logic [7:0] a, input logic d);
    logic got = 1'b0;
    bus.host_wr = wr; bus.host_rd = ~wr; bus.host_addr = a; bus.host_wdata = d;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (bus.host_ack) got = 1'b1;
    end
    chk("host_ack_timeout", {31'd0, got}, 1);
    bus.host_wr = 1'b0; bus.host_rd = 1'b0;
  endtask

  // Both sides issue n reads each, requests held continuously; checks first-ack latencies.
  task automatic both_txn(input int n, input logic [3:0] rx, input logic [3:0] ry, input logic [7:0] ha);
    int t0, rc, hc, rt, ht;
    rc = 0; hc = 0; rt = -1; ht = -1; t0 = cyc;
    bus.rat_rd = 1'b1; bus.rat_x = rx; bus.rat_y = ry;
    bus.host_rd = 1'b1; bus.host_addr = ha;
    for (int k = 0; k < 60 && (rc < n || hc < n); k++) begin
      @(negedge clk);
      if (bus.rat_ack) begin
        if (rc == 0) rt = cyc - t0;
        rc++;
        if (rc == n) bus.rat_rd = 1'b0;
      end
      if (bus.host_ack) begin
        if (hc == 0) ht = cyc - t0;
        hc++;
        if (hc == n) bus.host_rd = 1'b0;
      end
    end
    chk("both_rat_lat", rt, 2);
    chk("both_host_lat", ht, 5);
    chk("both_counts", rc + hc, 2 * n);
    bus.rat_rd = 1'b0; bus.host_rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] hd;
    int last_h, rat_c;
    rst = 1'b1; mem_clr = 1'b1; pl_we = 1'b0; pl_addr = 8'h00;
    bus.rat_rd = 0; bus.rat_wr = 0; bus.rat_x = 0; bus.rat_y = 0; bus.rat_wdata = 0;
    bus.host_rd = 0; bus.host_wr = 0; bus.host_addr = 0; bus.host_wdata = 0; bus.host_lock = 0;
    repeat (3) @(negedge clk);
    mem_clr = 1'b0;
    chk("rst_busy", {31'd0, bus.busy}, 0);
    chk("rst_mem_addr", {24'd0, bus.mem_addr}, 0);
    chk("rst_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 0);
    chk("rst_acks", {30'd0, bus.rat_ack, bus.host_ack}, 0);
    rst = 1'b0;

    // Rat write x=3,y=2 -> strobe at t+1 with address 0x23, ack at t+2.
    push(1'b0, 1'b0);
    bus.rat_wr = 1'b1; bus.rat_x = 4'd3; bus.rat_y = 4'd2; bus.rat_wdata = 1'b1;
    @(negedge clk);
    chk("wr_mem_wr", {31'd0, bus.mem_wr}, 1);
    chk("wr_mem_addr", {24'd0, bus.mem_addr}, 32'h23);
    chk("wr_mem_din", {31'd0, bus.mem_din}, 1);
    @(negedge clk);
    chk("wr_ack_t2", {31'd0, bus.rat_ack}, 1);
    bus.rat_wr = 1'b0; bus.rat_wdata = 1'b0;
    push(1'b0, 1'b1);
    rat_txn(1'b0, 4'd3, 4'd2, 1'b0);

    // Simultaneous requests after reset: rat, host, rat, host.
    do_reset();
    push(1'b0, 1'b1); push(1'b1, 1'b0); push(1'b0, 1'b1); push(1'b1, 1'b0);
    both_txn(2, 4'd3, 4'd2, 8'h00);

    // Host read of preloaded 0xF0.
    pl_addr = 8'hF0; pl_we = 1'b1;
    @(negedge clk); pl_we = 1'b0;
    push(1'b1, 1'b1);
    host_txn(1'b0, 8'hF0, 1'b0);

    // Host lock: 5 writes while rat read of 0x11 waits.
    hd = 5'b01011;
    for (int i = 0; i < 5; i++) push(1'b1, 1'b0);
    push(1'b0, 1'b1);
    last_h = 0; rat_c = 0;
    fork
      begin
        bus.host_lock = 1'b1;
        for (int i = 0; i < 5; i++) host_txn(1'b1, 8'h10 + 8'(i), hd[i]);
        last_h = cyc;
        bus.host_lock = 1'b0;
      end
      begin
        @(negedge clk);
        rat_txn(1'b0, 4'd1, 4'd1, 1'b0);
        rat_c = cyc;
      end
    join
    chk("lock_release_lat", {31'd0, (rat_c - last_h) <= 4 && (rat_c > last_h)}, 1);

    // Reset during ACCESS of a rat read; the request is re-arbitrated afterwards.
    @(negedge clk);
    push(1'b0, 1'b1);
    bus.rat_rd = 1'b1; bus.rat_x = 4'd3; bus.rat_y = 4'd2;
    @(negedge clk);
    chk("rstmid_access_rd", {31'd0, bus.mem_rd}, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", {31'd0, bus.busy}, 0);
    chk("rstmid_strobes", {30'd0, bus.mem_rd, bus.mem_wr}, 0);
    chk("rstmid_ack", {31'd0, bus.rat_ack}, 0);
    chk("rstmid_addr", {24'd0, bus.mem_addr}, 0);
    rst = 1'b0;
    rat_txn(1'b0, 4'd3, 4'd2, 1'b0);

`ifdef MAZE_ARB_STATS_EN
    do_reset();
    push(1'b0, 1'b1); push(1'b1, 1'b0);
    both_txn(1, 4'd3, 4'd2, 8'h00);
    push(1'b0, 1'b0); rat_txn(1'b0, 4'd0, 4'd0, 1'b0);
    push(1'b0, 1'b0); rat_txn(1'b1, 4'd5, 4'd5, 1'b0);
    push(1'b1, 1'b1); host_txn(1'b0, 8'hF0, 1'b0);
    @(negedge clk);
    chk("stat_rat_cnt", {16'd0, rat_cnt}, 3);
    chk("stat_host_cnt", {16'd0, host_cnt}, 2);
    chk("stat_conflict_cnt", {16'd0, conflict_cnt}, 1);
`endif

    repeat (3) @(negedge clk);
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/maze_mem_arbiter.md
Name: maze_mem_arbiter

Overview:
Shares the single-port, 1-bit-wide maze memory between two requesters: the rat solver (RD/WR/D_in/D_out traffic at cell {Y,X}) and a host port used for maze load and inspection. A 3-state sequencer grants one requester at a time, drives the memory strobes and returns a one-cycle ack. Arbitration is round-robin, plus a host lock for bulk loads. Sits between intelligent_rat and the maze RAM.

Parameters:
N, 4, coordinate width; memory address width is 2N, address = {y, x}

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rat_rd  in  1  rat read request, level, held until rat_ack
rat_wr  in  1  rat write request, level, held until rat_ack
rat_x  in  N  rat cell column
rat_y  in  N  rat cell row
rat_wdata  in  1  rat write data
rat_rdata  out  1  read data, valid while rat_ack=1
rat_ack  out  1  one-cycle completion pulse to rat
host_rd  in  1  host read request, level
host_wr  in  1  host write request, level
host_addr  in  2N  host cell address {y,x}
host_wdata  in  1  host write data
host_lock  in  1  host holds memory across transactions
host_rdata  out  1  read data, valid while host_ack=1
host_ack  out  1  one-cycle completion pulse to host
mem_addr  out  2N  memory address
mem_rd  out  1  memory read strobe; mem_dout valid next cycle
mem_wr  out  1  memory write strobe
mem_din  out  1  memory write data
mem_dout  in  1  memory read data
busy  out  1  high in ACCESS and RESP

Behaviour:
- States: IDLE, ACCESS, RESP. Reset -> IDLE, last_grant=HOST, locked=0; all outputs 0, mem_addr=0.
- IDLE: a requester is active if rd|wr. Winner:
  - Only one requester active -> that one.
  - Both active -> the one not equal to last_grant.
  - locked=1 -> host only; rat requests wait.
- On a win, capture op, address and wdata into registers, update last_grant, go to ACCESS.
- ACCESS (1 cycle): mem_addr and mem_din from the captured registers; mem_rd or mem_wr =1 per captured op. Next state RESP.
- RESP (1 cycle): winner's ack=1. For a read, winner's rdata = mem_dout. For a write, rdata=0. Next state IDLE.
- Latency: request seen in IDLE at cycle t, ack at t+2. Max throughput is 1 transaction per 3 cycles.
- rd and wr both high from one requester: treated as write.
- rdata outputs are 0 whenever ack=0.
- host_lock:
  - Sampled in RESP of a host transaction: locked <= host_lock.
  - locked clears in IDLE when host_lock=0.
  - While locked, rat is starved by design.
- Request dropped before ack: protocol violation. The transaction still completes and the ack is still issued.
- Reset mid-operation: next edge returns to IDLE with all strobes and acks 0. A write whose ACCESS cycle already occurred stays committed; no other partial state is kept.
- Memory strobes never assert outside ACCESS. At most one of mem_rd/mem_wr is high.

Optional Feature:
MAZE_ARB_STATS_EN
- Defined: adds outputs rat_cnt[15:0], host_cnt[15:0] and conflict_cnt[15:0].
  - rat_cnt / host_cnt: saturating counts of acks per requester.
  - conflict_cnt: IDLE cycles with both requesters active, or rat active while locked.
  - All three clear on rst.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package maze_pkg holds:
  - enum arb_state_t {IDLE, ACCESS, RESP}
  - enum req_id_t {REQ_RAT, REQ_HOST}
  - function addr_w(N) = 2N
  - stats counter width constant 16
- Sub-module rr_arb2: combinational 2-way round-robin picker with a mask input for the lock. Inputs req[1:0], last, mask_rat; outputs gnt_valid, gnt_id.

Test Plan:
- Rat write at x=3,y=2, data 1 (t=0) -> mem_wr=1 with mem_addr=8'h23 at t=1; rat_ack=1 at t=2. A following rat read of the same cell -> rat_rdata=1 with its ack.
- rat_rd and host_rd asserted together in IDLE after reset -> rat served first, then host (acks at t=2 and t=5). Repeated simultaneous requests alternate grants.
- Host asserts host_lock and writes 5 cells back-to-back while rat_rd is held -> 5 host acks and zero rat_ack. After lock drops, rat_ack arrives within 3 cycles of the next IDLE.
- Host read with memory preloaded to 1 at 8'hF0 -> host_rdata=1 only during host_ack; 0 on the surrounding cycles.
- rst asserted during ACCESS of a rat read -> next cycle IDLE, all outputs 0, no rat_ack. Request re-arbitrated after rst releases.
- (MAZE_ARB_STATS_EN) 3 rat and 2 host transactions with one simultaneous request -> rat_cnt=3, host_cnt=2, conflict_cnt=1.
